// File: rtl/mem_wb_stage_pkg.sv
// Shared pipeline definitions for the MEM/WB boundary.
// Holds the write-back control layout, the register-index width and the
// datapath width, plus the write-back data select helper.
package mem_wb_stage_pkg;

  localparam int WB_CTRL_W    = 2;
  localparam int REGWRITE_BIT = 0;
  localparam int MEMTOREG_BIT = 1;
  localparam int REG_IDX_W    = 5;
  localparam int DATA_W       = 32;

  // Memory read data wins when MemtoReg is set, otherwise the ALU result.
  function automatic logic [DATA_W-1:0] wb_select(
    input logic              memtoreg,
    input logic [DATA_W-1:0] rdata,
    input logic [DATA_W-1:0] alu_res
  );
    return memtoreg ? rdata : alu_res;
  endfunction

endpackage

// File: rtl/mem_wb_stage_perf_counter.sv
// Free-running wrap-around event counter.
// Ports:
//   CLK   - clock, counts on the rising edge
//   RSTn  - asynchronous active-low reset, clears the count
//   inc   - count this edge
//   count - current count, wraps from all-ones to zero
module perf_counter #(
  parameter int WIDTH = 64
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with write-back data select and retire/cycle
// performance counters.
// Ports:
//   CLK, RSTn             - clock, asynchronous active-low reset
//   stall, flush          - hazard unit hold / kill (flush has priority)
//   mem_valid, WB_control - MEM-stage valid and {MemtoReg, RegWrite}
//   R_DATA, result        - memory read data and ALU result
//   mem_rd, mem_pc        - destination register index and PC
//   wb_valid, wb_RegWrite - WB-stage valid and qualified register write
//   wb_rd, wb_WD, wb_pc   - write index, write data, PC
//   wb_retire             - one-cycle pulse per retired instruction
//   instret, cycle        - retired-instruction and cycle counters
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int          CNT_W  = 64,
  parameter logic [31:0] RST_PC = 32'h0000_0000
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 mem_valid,
  input  logic [WB_CTRL_W-1:0] WB_control,
  input  logic [DATA_W-1:0]    R_DATA,
  input  logic [DATA_W-1:0]    result,
  input  logic [REG_IDX_W-1:0] mem_rd,
  input  logic [31:0]          mem_pc,
  output logic                 wb_valid,
  output logic                 wb_RegWrite,
  output logic [REG_IDX_W-1:0] wb_rd,
  output logic [DATA_W-1:0]    wb_WD,
  output logic [31:0]          wb_pc,
  output logic                 wb_retire,
  output logic [CNT_W-1:0]     instret,
  output logic [CNT_W-1:0]     cycle
);

  logic                 r_valid_p1;
  logic [WB_CTRL_W-1:0] r_ctrl_p1;
  logic [DATA_W-1:0]    r_rdata_p1;
  logic [DATA_W-1:0]    r_result_p1;
  logic [REG_IDX_W-1:0] r_rd_p1;
  logic [31:0]          r_pc_p1;
  logic                 r_retire_p1;

  // MEM -> WB boundary. Data fields are reset too so that wb_WD reads zero
  // while in reset. A flush only kills valid; stale data is harmless because
  // every consumer is qualified by valid.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_valid_p1  <= 1'b0;
      r_ctrl_p1   <= '0;
      r_rdata_p1  <= '0;
      r_result_p1 <= '0;
      r_rd_p1     <= '0;
      r_pc_p1     <= RST_PC;
      r_retire_p1 <= 1'b0;
    end else if (flush) begin
      r_valid_p1  <= 1'b0;
      r_retire_p1 <= 1'b0;
    end else if (stall) begin
      // Held instruction already pulsed retire when it was loaded.
      r_retire_p1 <= 1'b0;
    end else begin
      r_valid_p1  <= mem_valid;
      r_ctrl_p1   <= WB_control;
      r_rdata_p1  <= R_DATA;
      r_result_p1 <= result;
      r_rd_p1     <= mem_rd;
      r_pc_p1     <= mem_pc;
      r_retire_p1 <= mem_valid;
    end
  end

  // WB stage outputs, combinational from registered fields only.
  assign wb_valid    = r_valid_p1;
  assign wb_RegWrite = r_valid_p1 & r_ctrl_p1[REGWRITE_BIT] & (r_rd_p1 != '0);
  assign wb_rd       = r_rd_p1;
  assign wb_WD       = wb_select(r_ctrl_p1[MEMTOREG_BIT], r_rdata_p1, r_result_p1);
  assign wb_pc       = r_pc_p1;
  assign wb_retire   = r_retire_p1;

  perf_counter #(.WIDTH(CNT_W)) u_instret (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .inc   (r_retire_p1),
    .count (instret)
  );

  perf_counter #(.WIDTH(CNT_W)) u_cycle (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .inc   (1'b1),
    .count (cycle)
  );

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios plus randomized traffic, all
// compared against a behavioural model of the write-back stage.
module tb_mem_wb_stage;

  localparam int          CNT_W  = 8;
  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic             CLK = 1'b0;
  logic             RSTn;
  logic             stall, flush, mem_valid;
  logic [1:0]       WB_control;
  logic [31:0]      R_DATA, result, mem_pc;
  logic [4:0]       mem_rd;
  logic             wb_valid, wb_RegWrite, wb_retire;
  logic [4:0]       wb_rd;
  logic [31:0]      wb_WD, wb_pc;
  logic [CNT_W-1:0] instret, cycle;

  mem_wb_stage #(.CNT_W(CNT_W), .RST_PC(RST_PC)) dut (
    .CLK(CLK), .RSTn(RSTn), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .WB_control(WB_control), .R_DATA(R_DATA),
    .result(result), .mem_rd(mem_rd), .mem_pc(mem_pc),
    .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd),
    .wb_WD(wb_WD), .wb_pc(wb_pc), .wb_retire(wb_retire),
    .instret(instret), .cycle(cycle)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Model: the instruction currently sitting in WB, plus event counts.
  logic             m_valid;
  logic [1:0]       m_ctrl;
  logic [31:0]      m_rdata, m_result, m_pc;
  logic [4:0]       m_rd;
  logic             m_retire;
  logic [CNT_W-1:0] m_instret, m_cycle;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_ctrl = 0; m_rdata = 0; m_result = 0; m_rd = 0;
    m_pc = RST_PC; m_retire = 0; m_instret = 0; m_cycle = 0;
  endtask

  // Every cycle the outputs are meaningful: data fields only while valid,
  // since a flushed slot may carry stale data.
  task automatic check_outputs();
    chk("wb_valid", 64'(wb_valid), 64'(m_valid));
    chk("wb_RegWrite", 64'(wb_RegWrite), 64'(m_valid && m_ctrl[0] && m_rd != 0));
    chk("wb_retire", 64'(wb_retire), 64'(m_retire));
    chk("instret", 64'(instret), 64'(m_instret));
    chk("cycle", 64'(cycle), 64'(m_cycle));
    if (m_valid) begin
      chk("wb_rd", 64'(wb_rd), 64'(m_rd));
      chk("wb_WD", 64'(wb_WD), 64'(m_ctrl[1] ? m_rdata : m_result));
      chk("wb_pc", 64'(wb_pc), 64'(m_pc));
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] c, input logic [31:0] rd_data,
                       input logic [31:0] res, input logic [4:0] rd, input logic [31:0] pc,
                       input logic st, input logic fl);
    mem_valid = v; WB_control = c; R_DATA = rd_data; result = res;
    mem_rd = rd; mem_pc = pc; stall = st; flush = fl;
  endtask

  task automatic drive_random(input logic st, input logic fl);
    drive(($urandom_range(3) != 0), 2'($urandom), $urandom, $urandom,
          (($urandom_range(5) == 0) ? 5'd0 : 5'($urandom)), $urandom, st, fl);
  endtask

  // One clock: advance the model with the inputs the DUT samples, then compare.
  task automatic step();
    @(posedge CLK);
    m_cycle = m_cycle + 1'b1;
    if (m_retire) m_instret = m_instret + 1'b1;
    if (flush) begin
      m_valid = 0; m_retire = 0;
    end else if (stall) begin
      m_retire = 0;
    end else begin
      m_valid = mem_valid; m_ctrl = WB_control; m_rdata = R_DATA;
      m_result = result; m_rd = mem_rd; m_pc = mem_pc; m_retire = mem_valid;
    end
    #1;
    check_outputs();
  endtask

  task automatic check_reset_values();
    chk("rst_valid", 64'(wb_valid), 64'd0);
    chk("rst_regwrite", 64'(wb_RegWrite), 64'd0);
    chk("rst_retire", 64'(wb_retire), 64'd0);
    chk("rst_rd", 64'(wb_rd), 64'd0);
    chk("rst_wd", 64'(wb_WD), 64'd0);
    chk("rst_pc", 64'(wb_pc), 64'h1000);
    chk("rst_instret", 64'(instret), 64'd0);
    chk("rst_cycle", 64'(cycle), 64'd0);
  endtask

  logic [CNT_W-1:0] snap_instret, snap_cycle;
  int bound;

  initial begin
    RSTn = 1'b0;
    drive(0, 2'b00, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    check_reset_values();
    check_outputs();

    @(negedge CLK);
    RSTn = 1'b1;
    step();
    chk("first_cycle", 64'(cycle), 64'd1);

    // Load path through memory data.
    drive(1, 2'b11, 32'hDEAD_BEEF, 32'h10, 5'd5, 32'h100, 0, 0);
    step();
    chk("load_wd", 64'(wb_WD), 64'hDEAD_BEEF);
    chk("load_regwrite", 64'(wb_RegWrite), 64'd1);
    chk("load_rd", 64'(wb_rd), 64'd5);
    chk("load_retire", 64'(wb_retire), 64'd1);

    // ALU path targeting x0 is never written.
    drive(1, 2'b01, 32'h5555_5555, 32'h1234, 5'd0, 32'h104, 0, 0);
    step();
    chk("x0_wd", 64'(wb_WD), 64'h1234);
    chk("x0_regwrite", 64'(wb_RegWrite), 64'd0);
    chk("x0_valid", 64'(wb_valid), 64'd1);

    // Stall holds instruction A while inputs churn; A retires once.
    drive(1, 2'b01, 32'h0, 32'hAAAA, 5'd7, 32'h40, 0, 0);
    step();
    snap_instret = m_instret;
    for (int i = 0; i < 3; i++) begin
      drive_random(1, 0);
      step();
      chk("stall_rd", 64'(wb_rd), 64'd7);
      chk("stall_wd", 64'(wb_WD), 64'hAAAA);
      chk("stall_pc", 64'(wb_pc), 64'h40);
    end
    chk("stall_instret", 64'(instret), 64'(snap_instret + 1'b1));

    // Flush wins over stall.
    drive(1, 2'b11, 32'h1, 32'h2, 5'd3, 32'h44, 1, 1);
    step();
    chk("flush_valid", 64'(wb_valid), 64'd0);
    chk("flush_regwrite", 64'(wb_RegWrite), 64'd0);
    chk("flush_retire", 64'(wb_retire), 64'd0);

    // Random traffic with one asynchronous reset mid-stall/mid-flush.
    for (int i = 0; i < 400; i++) begin
      drive_random(($urandom_range(3) == 0), ($urandom_range(7) == 0));
      step();
      if (i == 200) begin
        drive_random(1, 1);
        #2 RSTn = 1'b0;
        #1;
        model_reset();
        check_reset_values();
        check_outputs();
        @(negedge CLK);
        RSTn = 1'b1;
        drive_random(0, 0);
        step();
        chk("cycle_after_reset", 64'(cycle), 64'd1);
      end
    end

    // Drive retirements until instret is all-ones, then retire one more.
    bound = 0;
    while (m_instret != {CNT_W{1'b1}} && bound < 1000) begin
      drive(1, 2'b01, $urandom, $urandom, 5'($urandom), $urandom, 0, 0);
      step();
      bound++;
    end
    chk("wrap_reach_bound", 64'(m_instret), 64'(8'hFF));
    chk("wrap_pending_retire", 64'(wb_retire), 64'd1);
    snap_cycle = m_cycle;
    drive(0, 2'b00, 0, 0, 0, 0, 0, 0);
    step();
    chk("wrap_instret", 64'(instret), 64'd0);
    chk("wrap_cycle", 64'(cycle), 64'(snap_cycle + 1'b1));
    step();
    chk("wrap_cycle_next", 64'(cycle), 64'(snap_cycle + 2'd2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
